scan_chain_ctrl: RTL and testbench

Sequencer for a serial chain of negedge-clocked D flip-flops. It accepts a parallel word over a valid/ready handshake and shifts it into the chain LSB-first, one bit per cycle. While shifting it collects the bits returning from the chain's tail, then presents that captured word over a second valid/ready handshake. It sits between the configuration/register-access logic and any flip-flop bank built as a scan chain, and it is the only driver of the chain's data and enable inputs.

---
 rtl/scan_chain_ctrl.sv | 99 +++++++++
 tb/tb_scan_chain_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_ctrl.sv
// Sequencer for a negedge-clocked serial scan chain: shifts a parallel word in
// LSB-first while capturing the chain's return bits, then presents the captured word.
module scan_chain_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             scan_en,
    output logic             scan_di,
    input  logic             scan_do,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic [WIDTH-1:0] cap_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             last;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // All handshake and chain outputs decode from state alone; scan_di is
    // gated so it reads 0 whenever the chain is not shifting.
    always_comb begin
        state_next = state;
        load_ready = 1'b0;
        scan_en    = 1'b0;
        scan_di    = 1'b0;
        cap_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                busy       = 1'b0;
                if (load_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                scan_en = 1'b1;
                scan_di = sreg[0];
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                cap_valid = 1'b1;
                if (cap_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The counter holds on the final shift edge so it never wraps mid-transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg     <= '0;
            cnt      <= '0;
            cap_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        sreg <= load_data;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    sreg          <= {1'b0, sreg[WIDTH-1:1]};
                    cap_data[cnt] <= scan_do;
                    if (!last) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a negedge chain model that can act
// as a 1-stage loopback or a full 8-stage chain.
module tb_scan_chain_ctrl;

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       scan_en;
    logic       scan_di;
    logic       scan_do;
    logic       cap_valid;
    logic       cap_ready;
    logic [7:0] cap_data;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic       long_chain;
    logic       preload;
    logic [7:0] preload_val;
    logic       lb_ff;
    logic [7:0] chain;
    logic [7:0] cap;

    scan_chain_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .scan_en    (scan_en),
        .scan_di    (scan_di),
        .scan_do    (scan_do),
        .cap_valid  (cap_valid),
        .cap_ready  (cap_ready),
        .cap_data   (cap_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // chain[7] is the head, chain[0] the tail
    always @(negedge clk) begin
        if (preload) begin
            chain <= preload_val;
        end else if (scan_en) begin
            chain <= {scan_di, chain[7:1]};
            lb_ff <= scan_di;
        end
    end

    assign scan_do = long_chain ? chain[0] : lb_ff;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Call with the controller in IDLE; returns the captured word after the cap handshake.
    task automatic run_txn(input logic [7:0] d, output logic [7:0] c);
        load_data  = d;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq("shift_scan_en", 32'(scan_en), 32'd1);
            check_eq("shift_scan_di", 32'(scan_di), 32'(d[k]));
            tick();
        end
        check_eq("done_cap_valid", 32'(cap_valid), 32'd1);
        check_eq("done_scan_en", 32'(scan_en), 32'd0);
        c = cap_data;
        cap_ready = 1'b1;
        tick();
        cap_ready = 1'b0;
        check_eq("idle_load_ready", 32'(load_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_load_ready"}, 32'(load_ready), 32'd1);
        check_eq({tag, "_scan_en"},    32'(scan_en),    32'd0);
        check_eq({tag, "_scan_di"},    32'(scan_di),    32'd0);
        check_eq({tag, "_cap_valid"},  32'(cap_valid),  32'd0);
        check_eq({tag, "_cap_data"},   32'(cap_data),   32'd0);
        check_eq({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    initial begin
        int wait_cnt;
        rst_n       = 1'b1;
        load_valid  = 1'b0;
        load_data   = 8'h00;
        cap_ready   = 1'b0;
        long_chain  = 1'b0;
        preload     = 1'b0;
        preload_val = 8'h00;

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("post_rst_load_ready", 32'(load_ready), 32'd1);
            check_eq("post_rst_scan_en", 32'(scan_en), 32'd0);
        end

        // Loopback with A5
        run_txn(8'hA5, cap);
        check_eq("loopback_A5", 32'(cap), 32'hA5);

        // Full 8-stage chain preloaded with 3C, then F0, then 00
        long_chain  = 1'b1;
        preload_val = 8'h3C;
        preload     = 1'b1;
        tick();
        preload = 1'b0;
        run_txn(8'hF0, cap);
        check_eq("chain_cap_1", 32'(cap), 32'h1E);
        run_txn(8'h00, cap);
        check_eq("chain_readback_F0", 32'(cap), 32'h78);
        long_chain = 1'b0;

        // Back-pressure with load_valid held high
        load_data  = 8'h5A;
        load_valid = 1'b1;
        wait_cnt   = 0;
        tick();
        while (!cap_valid && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        check_eq("bp_reach_done", 32'(cap_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            check_eq("bp_cap_valid", 32'(cap_valid), 32'd1);
            check_eq("bp_cap_data", 32'(cap_data), 32'h5A);
            check_eq("bp_load_ready", 32'(load_ready), 32'd0);
            check_eq("bp_scan_en", 32'(scan_en), 32'd0);
            tick();
        end
        cap_ready = 1'b1;
        tick();
        cap_ready = 1'b0;
        check_eq("bp_idle_busy", 32'(busy), 32'd0);
        check_eq("bp_idle_load_ready", 32'(load_ready), 32'd1);
        tick();
        load_valid = 1'b0;
        check_eq("bp_second_accept_busy", 32'(busy), 32'd1);
        check_eq("bp_second_accept_scan_en", 32'(scan_en), 32'd1);
        for (int i = 0; i < 8; i++) tick();
        check_eq("bp_second_cap_valid", 32'(cap_valid), 32'd1);
        check_eq("bp_second_cap_data", 32'(cap_data), 32'h5A);
        cap_ready = 1'b1;
        tick();
        cap_ready = 1'b0;

        // Back-to-back: one IDLE cycle per 10-cycle transaction
        load_data  = 8'h33;
        load_valid = 1'b1;
        cap_ready  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            check_eq("b2b_busy", 32'(busy), (c % 10 != 0) ? 32'd1 : 32'd0);
            check_eq("b2b_cap_valid", 32'(cap_valid), (c % 10 == 9) ? 32'd1 : 32'd0);
            tick();
        end
        load_valid = 1'b0;
        cap_ready  = 1'b0;
        check_eq("b2b_end_idle", 32'(busy), 32'd0);

        // Reset asserted at cnt=3 during SHIFT
        load_data  = 8'hFF;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        tick();
        check_eq("mid_shift_scan_en", 32'(scan_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        rst_n = 1'b1;
        tick();
        run_txn(8'h01, cap);
        check_eq("after_rst_loopback_01", 32'(cap), 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
